// File: rtl/snake_dir_control.sv
// Snake direction controller: arbitrates key pulses, filters illegal turns, queues up to two
// turns and emits the periodic move tick with the direction to apply on it.
module snake_dir_control #(
    parameter int unsigned STEP_TICKS = 2000
) (
    input  logic       Clk_10khz,
    input  logic       Rst_n,
    input  logic       Key_left,
    input  logic       Key_right,
    input  logic       Key_up,
    input  logic       Key_down,
    input  logic       Game_over,
    input  logic       Restart,
    output logic [1:0] Dir,
    output logic       Move_tick,
    output logic       Running
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    localparam logic [1:0]  DirUp    = 2'b00;
    localparam logic [1:0]  DirDown  = 2'b01;
    localparam logic [1:0]  DirLeft  = 2'b10;
    localparam logic [1:0]  DirRight = 2'b11;
    localparam logic [15:0] CntLast  = 16'(STEP_TICKS - 1);

    state_e      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  last_dir_q, last_dir_d;
    logic [1:0]  q0_q, q0_d;
    logic [1:0]  q1_q, q1_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] cnt_q, cnt_d;
    logic        move_tick_q, move_tick_d;
    logic        running_q, running_d;

    logic        key_any;
    logic [1:0]  key_dir;
    logic        wrap;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        legal;

    // Fixed priority: up > down > left > right.
    always_comb begin
        key_any = Key_up | Key_down | Key_left | Key_right;
        if (Key_up) begin
            key_dir = DirUp;
        end else if (Key_down) begin
            key_dir = DirDown;
        end else if (Key_left) begin
            key_dir = DirLeft;
        end else begin
            key_dir = DirRight;
        end
    end

    // Reversal flips bit 0 within each axis pair.
    assign legal = (key_dir != last_dir_q) && (key_dir != (last_dir_q ^ 2'b01));
    assign wrap  = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        last_dir_d  = last_dir_q;
        q0_d        = q0_q;
        q1_d        = q1_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        move_tick_d = 1'b0;
        pop         = 1'b0;
        push_req    = 1'b0;
        push        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (key_any) begin
                    state_d  = StRun;
                    push_req = 1'b1;
                end
            end
            StRun: begin
                if (Game_over) begin
                    state_d = StHalt;
                    count_d = 2'd0;
                end else begin
                    push_req = key_any;
                    if (wrap) begin
                        cnt_d       = 16'd0;
                        move_tick_d = 1'b1;
                        pop         = (count_q != 2'd0);
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StHalt: begin
                count_d = 2'd0;
                if (Restart) begin
                    state_d    = StIdle;
                    dir_d      = DirRight;
                    last_dir_d = DirRight;
                    cnt_d      = 16'd0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A pop in the same cycle frees the slot a push into a full queue needs.
        push = push_req && legal && ((count_q != 2'd2) || pop);

        if (pop) begin
            dir_d   = q0_q;
            q0_d    = q1_q;
            count_d = count_q - 2'd1;
        end
        if (push) begin
            if (count_d == 2'd0) begin
                q0_d = key_dir;
            end else begin
                q1_d = key_dir;
            end
            count_d    = count_d + 2'd1;
            last_dir_d = key_dir;
        end

        running_d = (state_d == StRun);
    end

    always_ff @(posedge Clk_10khz or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            dir_q       <= DirRight;
            last_dir_q  <= DirRight;
            q0_q        <= DirRight;
            q1_q        <= DirRight;
            count_q     <= 2'd0;
            cnt_q       <= 16'd0;
            move_tick_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            last_dir_q  <= last_dir_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            move_tick_q <= move_tick_d;
            running_q   <= running_d;
        end
    end

    assign Dir       = dir_q;
    assign Move_tick = move_tick_q;
    assign Running   = running_q;

endmodule

// File: tb/tb_snake_dir_control.sv
// Directed self-checking bench for snake_dir_control with a 4-cycle step period.
module tb_snake_dir_control;

    logic       Clk_10khz;
    logic       Rst_n;
    logic       Key_left;
    logic       Key_right;
    logic       Key_up;
    logic       Key_down;
    logic       Game_over;
    logic       Restart;
    logic [1:0] Dir;
    logic       Move_tick;
    logic       Running;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int ticks;

    snake_dir_control #(
        .STEP_TICKS(4)
    ) dut (
        .Clk_10khz(Clk_10khz),
        .Rst_n    (Rst_n),
        .Key_left (Key_left),
        .Key_right(Key_right),
        .Key_up   (Key_up),
        .Key_down (Key_down),
        .Game_over(Game_over),
        .Restart  (Restart),
        .Dir      (Dir),
        .Move_tick(Move_tick),
        .Running  (Running)
    );

    initial Clk_10khz = 1'b0;
    always #5 Clk_10khz = ~Clk_10khz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Keys ordered {up, down, left, right}; driven for exactly one sampling edge.
    task automatic pulse(input logic [3:0] k);
        {Key_up, Key_down, Key_left, Key_right} = k;
        @(negedge Clk_10khz);
        {Key_up, Key_down, Key_left, Key_right} = 4'b0000;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge Clk_10khz);
            cycles++;
        end while (Move_tick !== 1'b1 && cycles < 20);
        check("tick_seen", 32'(Move_tick), 32'd1);
    endtask

    task automatic count_ticks(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk_10khz);
            if (Move_tick === 1'b1) seen++;
        end
    endtask

    task automatic do_reset();
        {Key_up, Key_down, Key_left, Key_right} = 4'b0000;
        Game_over = 1'b0;
        Restart   = 1'b0;
        Rst_n     = 1'b0;
        @(negedge Clk_10khz);
        @(negedge Clk_10khz);
        Rst_n = 1'b1;
        @(negedge Clk_10khz);
    endtask

    initial begin
        Rst_n = 1'b0;
        {Key_up, Key_down, Key_left, Key_right} = 4'b0000;
        Game_over = 1'b0;
        Restart   = 1'b0;
        #12;
        check("rst_dir", 32'(Dir), 32'd3);
        check("rst_tick", 32'(Move_tick), 32'd0);
        check("rst_running", 32'(Running), 32'd0);

        // Start with Key_up from IDLE
        do_reset();
        count_ticks(6, ticks);
        check("idle_no_tick", ticks, 0);
        check("idle_not_running", 32'(Running), 32'd0);
        pulse(4'b1000);
        check("start_running", 32'(Running), 32'd1);
        check("start_dir_hold", 32'(Dir), 32'd3);
        wait_tick(cyc);
        check("first_tick_latency", cyc, 4);
        check("first_tick_dir", 32'(Dir), 32'd0);
        wait_tick(cyc);
        check("tick_period", cyc, 4);
        check("second_tick_dir", 32'(Dir), 32'd0);
        @(negedge Clk_10khz);
        check("tick_one_cycle", 32'(Move_tick), 32'd0);

        // Reverse and duplicate turns are dropped
        do_reset();
        pulse(4'b0001);
        pulse(4'b0010);
        pulse(4'b0001);
        wait_tick(cyc);
        check("rev_dup_dropped", 32'(Dir), 32'd3);
        pulse(4'b0100);
        wait_tick(cyc);
        check("down_applied", 32'(Dir), 32'd1);

        // Full queue drops the third turn
        do_reset();
        pulse(4'b0001);
        pulse(4'b1000);
        pulse(4'b0010);
        pulse(4'b0100);
        wait_tick(cyc);
        check("q_tick1_lat", cyc, 1);
        check("q_tick1_dir", 32'(Dir), 32'd0);
        wait_tick(cyc);
        check("q_tick2_dir", 32'(Dir), 32'd2);
        wait_tick(cyc);
        check("q_tick3_dir", 32'(Dir), 32'd2);

        // Third turn lands on the wrap edge: pop and push together
        do_reset();
        pulse(4'b0001);
        pulse(4'b1000);
        pulse(4'b0010);
        @(negedge Clk_10khz);
        pulse(4'b0100);
        check("pp_tick", 32'(Move_tick), 32'd1);
        check("pp_tick1_dir", 32'(Dir), 32'd0);
        wait_tick(cyc);
        check("pp_tick2_dir", 32'(Dir), 32'd2);
        wait_tick(cyc);
        check("pp_tick3_dir", 32'(Dir), 32'd1);

        // Simultaneous up+left: only up taken
        do_reset();
        pulse(4'b0001);
        pulse(4'b1010);
        wait_tick(cyc);
        check("sim_dir", 32'(Dir), 32'd0);
        pulse(4'b0100);
        wait_tick(cyc);
        check("sim_last_dir_up", 32'(Dir), 32'd0);

        // Game over on the wrap cycle, then restart
        do_reset();
        pulse(4'b0001);
        pulse(4'b1000);
        @(negedge Clk_10khz);
        @(negedge Clk_10khz);
        Game_over = 1'b1;
        @(negedge Clk_10khz);
        Game_over = 1'b0;
        check("go_no_tick", 32'(Move_tick), 32'd0);
        check("go_not_running", 32'(Running), 32'd0);
        check("go_dir_hold", 32'(Dir), 32'd3);
        pulse(4'b1000);
        pulse(4'b0100);
        count_ticks(12, ticks);
        check("halt_no_tick", ticks, 0);
        check("halt_not_running", 32'(Running), 32'd0);
        check("halt_dir", 32'(Dir), 32'd3);
        Restart = 1'b1;
        @(negedge Clk_10khz);
        Restart = 1'b0;
        check("restart_not_running", 32'(Running), 32'd0);
        check("restart_dir", 32'(Dir), 32'd3);
        count_ticks(6, ticks);
        check("restart_idle_no_tick", ticks, 0);
        pulse(4'b0100);
        check("restart_run", 32'(Running), 32'd1);
        wait_tick(cyc);
        check("restart_tick_lat", cyc, 4);
        check("restart_flushed_dir", 32'(Dir), 32'd1);

        // Asynchronous reset while Move_tick is high and the queue is full
        do_reset();
        pulse(4'b0001);
        pulse(4'b1000);
        pulse(4'b0010);
        @(negedge Clk_10khz);
        pulse(4'b0100);
        check("ar_tick_before", 32'(Move_tick), 32'd1);
        #1;
        Rst_n = 1'b0;
        #1;
        check("ar_tick_cleared", 32'(Move_tick), 32'd0);
        check("ar_dir", 32'(Dir), 32'd3);
        check("ar_running", 32'(Running), 32'd0);
        @(negedge Clk_10khz);
        Rst_n = 1'b1;
        count_ticks(10, ticks);
        check("ar_no_tick_after", ticks, 0);
        check("ar_idle", 32'(Running), 32'd0);
        pulse(4'b0100);
        wait_tick(cyc);
        check("ar_restart_lat", cyc, 4);
        check("ar_queue_cleared", 32'(Dir), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/snake_dir_control.md
# snake_dir_control

Direction controller and step scheduler for the Snake game. It consumes the one-cycle debounced key pulses from the key-check stage and arbitrates key pulses that arrive in the same cycle. It rejects illegal turns, buffers up to two pending turns, and emits the periodic move tick together with the direction the snake body logic applies on that tick. It sits between the key-check module and the snake position/body update logic, all in the 10 kHz domain.

## Interface
- STEP_TICKS, 2000: clock cycles per snake step (200 ms at 10 kHz); legal range 2..65535
- Clk_10khz  input  1  system clock, 10 kHz
- Rst_n  input  1  asynchronous active-low reset
- Key_left  input  1  one-cycle pulse, left pressed
- Key_right  input  1  one-cycle pulse, right pressed
- Key_up  input  1  one-cycle pulse, up pressed
- Key_down  input  1  one-cycle pulse, down pressed
- Game_over  input  1  level from body logic: collision detected
- Restart  input  1  one-cycle pulse: return from HALT to IDLE
- Dir  output  2  applied direction: 00 up, 01 down, 10 left, 11 right
- Move_tick  output  1  one-cycle strobe: advance snake one cell using Dir
- Running  output  1  high while in RUN

## Operation
- Reset (async, Rst_n low):
  - Dir=11 (right), Last_dir=11, queue empty (count 0), step counter 0, Move_tick=0, Running=0.
  - State goes to IDLE.
- States:
  - IDLE: counter held at 0, no ticks. Any key pulse moves to RUN next edge, and that key is also processed as a turn request.
  - RUN: counter runs; Running=1. Game_over=1 moves to HALT.
  - HALT: counter held, Move_tick=0, queue flushed. Restart moves to IDLE and reloads all reset values except the state itself.
- Key arbitration: when several pulses arrive in one cycle, exactly one is taken, with priority up > down > left > right. The others are discarded.
- Turn acceptance, checked against Last_dir (last accepted direction, not the applied Dir):
  - Same as Last_dir: drop.
  - Reverse of Last_dir (up/down, left/right): drop.
  - Queue full (count 2) with no pop in the same cycle: drop.
  - Otherwise push to queue tail and set Last_dir to the new direction.
- Queue: 2-entry FIFO of 2-bit directions. A push and a pop in the same cycle are both performed; count is unchanged.
- Step counter: 16-bit, counts 0..STEP_TICKS-1 in RUN, then wraps to 0.
  - On the wrap edge, Move_tick is set to 1 for one cycle.
  - On the same wrap edge, if the queue is non-empty, Dir is loaded from the head and the head is popped. If the queue is empty, Dir holds.
- Game_over has priority: in the cycle it is sampled high, no tick, no pop and no push occur, and the state goes to HALT.
- Keys pressed in HALT are ignored.

## Timing
- All outputs are registered; no combinational path from input to output.
- The first Move_tick comes exactly STEP_TICKS cycles after the edge that enters RUN. Later ticks are exactly STEP_TICKS cycles apart.
- Dir changes only on a Move_tick edge, or on reset/Restart. The new Dir is valid in the same cycle Move_tick is high.
- Key-to-Dir latency: the next tick after acceptance if the queue was empty. Each further queued turn is applied one tick later.
- Game_over sampled high in cycle n: Running=0 and Move_tick=0 from cycle n+1. A tick that would have occurred at n+1 is suppressed.
- Restart in HALT: IDLE from the next edge, with Dir=11 and the queue empty.
- Async reset mid-tick clears Move_tick immediately, with no completion.

## Test plan
Use STEP_TICKS=4 in simulation.
- Start and default direction: after reset, pulse Key_up once -> RUN next edge; first Move_tick 4 cycles later with Dir=00; then ticks every 4 cycles with Dir=00.
- Reversal and duplicate rejection: in RUN with Dir=11 and the queue empty, pulse Key_left -> dropped, Dir stays 11; pulse Key_right -> dropped; pulse Key_down -> applied at next tick (Dir=01).
- Queue depth and ordering:
  - Dir=11; pulse Key_up, then Key_left, then Key_down within one step period -> the first two are queued and Key_down is dropped (queue full).
  - Ticks apply 00 and then 10; the third tick keeps 10.
  - Repeat with Key_up, Key_left, Key_down, where Key_down lands in the wrap cycle itself, so the pop frees a slot -> Key_down is accepted (pop+push); ticks apply 00, 10, then 01.
- Simultaneous keys: Dir=11; Key_up and Key_left pulsed in the same cycle -> only 00 is queued; Last_dir=00; next tick Dir=00.
- Game over and restart:
  - Queue holds one entry; assert Game_over in a wrap cycle -> no Move_tick, Running=0 next cycle, queue flushed, keys ignored.
  - Pulse Restart -> IDLE with Dir=11; a key pulse restarts RUN.
- Asynchronous reset: assert Rst_n low mid-period with a full queue -> all outputs take reset values immediately, without waiting for a clock edge; no Move_tick after release until a key pulse and 4 further cycles.
